mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Parametrised sequential multiplier for the execute stage; successor to the single-cycle 32x32 unsigned multiplier.
- Handles both MULT (signed) and MULTU (unsigned) with one radix-2 shift-add datapath, one operand bit per clock.
- Uses a start/busy/done handshake so the pipeline can stall on busy and write HI/LO from z when done pulses.
- Supports abort through cancel, for exceptions and branch flush.

Parameters:
- WIDTH, 32, operand width in bits; z is 2*WIDTH bits; must be at least 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- signed_op  input  1  1 = two's-complement operands (MULT), 0 = unsigned (MULTU); sampled with start
- cancel  input  1  synchronous abort of the current operation
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in progress (CALC or FIX)
- done  output  1  one-cycle pulse; z is valid in this cycle
- z  output  2*WIDTH  product; {HI,LO} when WIDTH=32

Behaviour:
- Reset: rst_n low forces the following regardless of clk: state=IDLE, busy=0, done=0, z=0, counter=0, internal registers=0. Reset asserted mid-operation discards the operation with no done.
- States: IDLE, CALC, FIX.
- IDLE -> CALC on an edge with start=1 and cancel=0. On that edge:
  - Latch magnitudes |a| and |b| when signed_op=1; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) as a WIDTH-bit unsigned value.
  - Latch the raw operands when signed_op=0.
  - Latch neg = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Clear the accumulator; set counter=0.
- CALC, one edge per multiplier bit, LSB first: if the current multiplier bit is 1, accumulator += multiplicand << counter (2*WIDTH-bit add, no overflow possible); counter++. After WIDTH edges -> FIX.
- FIX, one edge: z <= neg ? (~acc + 1) : acc, truncated to 2*WIDTH bits. done=1 for the cycle after this edge; state -> IDLE.
- Latency: done is high in the cycle after the (WIDTH+2)-th rising edge counted from the accepting edge, i.e. WIDTH+2 cycles, 34 for WIDTH=32.
- busy: 1 in CALC and FIX; 0 in IDLE, including the done cycle. The pipeline may issue a new start in the done cycle; it is accepted on that edge (back-to-back).
- z: registered; changes only on the FIX edge and on reset. Between operations it holds the last product.
- start while busy: ignored; no queuing; operands are not resampled.
- cancel=1 in CALC or FIX: next edge -> IDLE, no done, z unchanged.
- cancel=1 in IDLE: start is ignored on that edge.
- cancel and the FIX edge coincide: cancel wins; z is not updated and no done pulse.
- Operand inputs may change freely after the accepting edge.
- Unsigned result equals a*b mod 2^(2*WIDTH), which is exact. Signed result equals the exact two's-complement product, 2*WIDTH bits.

Test Plan:
- Reset mid-CALC: start with a=5, b=7; pull rst_n low 10 cycles later -> busy=0, done=0, z=0 immediately; no done pulse afterwards.
- Unsigned max: signed_op=0, a=b=32'hFFFFFFFF -> done exactly 34 cycles after start; z=64'hFFFFFFFE_00000001; busy high for 33 cycles.
- Signed mixed and extremes:
  - signed_op=1, a=32'hFFFFFFFD (-3), b=7 -> z=64'hFFFFFFFF_FFFFFFEB (-21).
  - a=b=32'h80000000 -> z=64'h40000000_00000000.
  - Same operands with signed_op=0 -> z=64'h40000000_00000000.
- Start while busy: start a=2, b=3; pulse start with a=100, b=100 in cycle 5 -> single done with z=6; the second request is ignored.
- Cancel: start a=9, b=9, then cancel in cycle 12 -> no done; z holds its previous value; a new start a=4, b=4 is accepted afterwards and gives z=16.
- Back-to-back and WIDTH=8 instance:
  - Assert start in the done cycle -> accepted; second done follows 34 cycles later.
  - WIDTH=8, signed a=8'h80, b=8'h7F -> z=16'hC080 after 10 cycles.

Source files
------------

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier for the execute stage.
// Handles MULT (signed) and MULTU (unsigned) on one datapath: signed operands
// are reduced to magnitudes on entry, and the sign is applied in the FIX state.
// The multiplier is consumed one bit per clock, LSB first, through a start/busy/done handshake.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; z holds the last product
// CALC  | one multiplier bit per edge, WIDTH edges in total
// FIX   | apply the sign, register z, pulse done on the following cycle
module mul_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic                 cancel,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   z
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
  localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  // Operand magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (signed_op && a[WIDTH-1]) a_mag = ~a + ONE_W;
    if (signed_op && b[WIDTH-1]) b_mag = ~b + ONE_W;
  end

  assign busy = (state == CALC) || (state == FIX);

  // Sequencing and datapath: the multiplicand shifts left while the multiplier
  // shifts right, which equals adding multiplicand << counter for each set bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      z      <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end
        end
        CALC: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
            if (cnt == LAST) state <= FIX;
          end
        end
        FIX: begin
          // A cancel landing on this edge drops the result entirely.
          if (!cancel) begin
            z    <= neg ? (~acc + ONE_2W) : acc;
            done <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: a 32-bit instance covering handshake, cancel,
// reset and signed/unsigned corners, plus an 8-bit instance.
module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_op = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [63:0] z;

  logic        start8 = 1'b0;
  logic        signed8 = 1'b0;
  logic        cancel8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8;
  logic        done8;
  logic [15:0] z8;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .cancel(cancel), .a(a), .b(b), .busy(busy), .done(done), .z(z)
  );

  mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_op(signed8),
    .cancel(cancel8), .a(a8), .b(b8), .busy(busy8), .done(done8), .z(z8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and let the accepting edge pass; afterwards we are in cycle 1.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    a = ta; b = tb; signed_op = ts; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Cycles from the accepting edge until done is seen (bounded), and busy cycles seen.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 1;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 100) begin
      tick();
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (done) c++;
    end
  endtask

  initial begin
    int lat, bcnt, c;

    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_z", z, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // reset mid-CALC
    issue(32'd5, 32'd7, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    check("midcalc_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_busy", 64'(busy), 64'd0);
    check("rst_async_done", 64'(done), 64'd0);
    check("rst_async_z", z, 64'd0);
    tick();
    rst_n = 1'b1;
    count_done(40, c);
    check("rst_no_done", 64'(c), 64'd0);

    // unsigned max
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(lat, bcnt);
    check("umax_latency", 64'(lat), 64'd34);
    check("umax_busy_cycles", 64'(bcnt), 64'd33);
    check("umax_busy_in_done", 64'(busy), 64'd0);
    check("umax_z", z, 64'hFFFF_FFFE_0000_0001);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("z_holds", z, 64'hFFFF_FFFE_0000_0001);

    // signed mixed and extremes
    issue(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(lat, bcnt);
    check("s_m3x7", z, 64'hFFFF_FFFF_FFFF_FFEB);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(lat, bcnt);
    check("s_min_sq", z, 64'h4000_0000_0000_0000);
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(lat, bcnt);
    check("u_min_sq", z, 64'h4000_0000_0000_0000);
    issue(32'd9, 32'hFFFF_FFFF, 1'b1);
    wait_done(lat, bcnt);
    check("s_9xm1", z, 64'hFFFF_FFFF_FFFF_FFF7);
    issue(32'hFFFF_FFFA, 32'hFFFF_FFF9, 1'b1);
    wait_done(lat, bcnt);
    check("s_m6xm7", z, 64'd42);

    // start while busy is ignored
    issue(32'd2, 32'd3, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    a = 32'd100; b = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, bcnt);
    check("busy_start_z", z, 64'd6);
    count_done(40, c);
    check("busy_start_single_done", 64'(c), 64'd0);

    // cancel in CALC
    issue(32'd9, 32'd9, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 64'(busy), 64'd0);
    count_done(40, c);
    check("cancel_no_done", 64'(c), 64'd0);
    check("cancel_z_held", z, 64'd6);
    issue(32'd4, 32'd4, 1'b0);
    wait_done(lat, bcnt);
    check("after_cancel_latency", 64'(lat), 64'd34);
    check("after_cancel_z", z, 64'd16);

    // cancel in IDLE blocks start
    a = 32'd3; b = 32'd3; start = 1'b1; cancel = 1'b1;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("idle_cancel_busy", 64'(busy), 64'd0);

    // cancel coinciding with the FIX edge
    issue(32'd3, 32'd5, 1'b0);
    for (int i = 0; i < 32; i++) tick();
    check("fix_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("fix_cancel_done", 64'(done), 64'd0);
    check("fix_cancel_z", z, 64'd16);
    count_done(5, c);
    check("fix_cancel_no_done", 64'(c), 64'd0);

    // back-to-back: new start in the done cycle
    issue(32'h1234_5678, 32'h10, 1'b0);
    wait_done(lat, bcnt);
    check("b2b_first_z", z, 64'h0000_0001_2345_6780);
    a = 32'd6; b = 32'hFFFF_FFF9; signed_op = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_accepted", 64'(busy), 64'd1);
    wait_done(lat, bcnt);
    check("b2b_latency", 64'(lat), 64'd34);
    check("b2b_z", z, 64'hFFFF_FFFF_FFFF_FFD6);

    // WIDTH=8 instance
    a8 = 8'h80; b8 = 8'h7F; signed8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      tick();
      lat++;
    end
    check("w8_latency", 64'(lat), 64'd10);
    check("w8_z", 64'(z8), 64'hC080);
    a8 = 8'hFF; b8 = 8'hFF; signed8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      tick();
      lat++;
    end
    check("w8_umax_z", 64'(z8), 64'hFE01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
